audio_dc_block_out: RTL
=======================

AUDIO_DC_BLOCK_OUT -- requirements
Module: audio_dc_block_out

Interface
REQ-001 SHALL have parameter ALPHA_SHIFT, default 10, sets the high-pass pole at 1 - 2^-ALPHA_SHIFT (legal range 4..15).
REQ-002 SHALL have port clk  in  1  single rising-edge clock for all logic.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port sample_valid  in  1  one-cycle strobe marking a new input sample.
REQ-005 SHALL have port in  in  16  unsigned mixer-stage output, midscale 32768.
REQ-006 SHALL have port volume  in  4  attenuation as an arithmetic right shift, 0..15.
REQ-007 SHALL have port out  out  16  signed DC-blocked, attenuated, saturated sample.
REQ-008 SHALL have port out_valid  out  1  one-cycle strobe when out updates.
REQ-009 SHALL have port clip  out  1  one-cycle strobe, coincident with out_valid, when saturation occurred.
REQ-010 SHALL have port overrun  out  1  one-cycle strobe when a sample_valid is dropped.

Function
REQ-011 SHALL use an FSM with states IDLE, CENTER, FILTER, SCALE, OUTPUT, one cycle each; all states except IDLE return to IDLE via OUTPUT.
REQ-012 SHALL, in IDLE on sample_valid=1, latch in and volume and move to CENTER.
REQ-013 SHALL, in CENTER, form x = in - 32768 as 17-bit signed.
REQ-014 SHALL, in FILTER, compute y = ((x - x_prev) <<< 16) + y_prev - (y_prev >>> ALPHA_SHIFT) in 40-bit signed, then set x_prev = x and y_prev = y.
REQ-015 SHALL, in SCALE, form s = (y >>> 16) >>> volume using arithmetic (floor) shifts.
REQ-016 SHALL, in OUTPUT, saturate s to [-32768, 32767], register it on out, and pulse out_valid; clip pulses iff the value was limited.
REQ-017 SHALL produce out_valid exactly 4 cycles after the accepted sample_valid cycle, giving a minimum sample spacing of 5 cycles.
REQ-018 SHALL ignore sample_valid in any non-IDLE state and pulse overrun the following cycle; filter state is unaffected.
REQ-019 SHALL accept sample_valid in the cycle the FSM returns to IDLE after OUTPUT.
REQ-020 SHALL hold out stable between out_valid strobes.
REQ-021 SHALL ignore changes to volume except when it is latched in IDLE.

Reset
REQ-022 SHALL, while reset_n=0, force: state=IDLE, out=0, out_valid=0, clip=0, overrun=0, x_prev=0, y_prev=0.
REQ-023 SHALL abandon any in-flight sample on reset, with no out_valid for it after release.
REQ-024 SHALL, on the first clk edge after reset_n rises, accept sample_valid normally.

Configuration
REQ-025 SHALL, when macro AUDIO_DC_BLOCK_CLIP_COUNT_EN is defined, add output clip_count[7:0]; it increments on each clip pulse, saturates at 255, and is cleared by reset.
REQ-026 SHALL, when AUDIO_DC_BLOCK_CLIP_COUNT_EN is undefined, omit the clip_count port and its logic; all other behaviour is identical.

Verification
REQ-027 SHALL cover reset: hold reset_n=0 with sample_valid toggling -> out=0, out_valid=0, no overrun.
REQ-028 SHALL cover the step response: volume=0, from reset apply in=40000, then in=40000 again (>=5 cycles apart) -> out=7232 then out=7224, each out_valid 4 cycles after its strobe.
REQ-029 SHALL cover saturation: from reset apply in=0 -> out=-32768, clip=0; then in=65535 -> out=32767, clip=1 (unsaturated value 32799).
REQ-030 SHALL cover attenuation: from reset, volume=2, in=40000 -> out=1808; change volume mid-sample -> result is unchanged.
REQ-031 SHALL cover overrun: sample_valid on cycles 0 and 2 -> one out_valid at cycle 4, overrun at cycle 3, second sample has no effect on x_prev.
REQ-032 SHALL cover reset mid-operation: assert reset_n in FILTER -> no out_valid; the next sample in=40000 after release gives out=7232.

Source files
------------

// File: rtl/audio_dc_block_out.sv
`default_nettype none
// ============================================================================
// Module      : audio_dc_block_out
// Description : Output-stage DC blocker for a 16-bit unsigned audio stream.
//               Each accepted sample is recentred, passed through a one-pole
//               high-pass filter, attenuated by a shift and saturated to a
//               signed 16-bit result, four cycles after it was accepted.
//               Optional feature macro: AUDIO_DC_BLOCK_CLIP_COUNT_EN adds a
//               saturating 8-bit count of clip events (clip_count).
// Revision    : 1.0 - initial release
// ============================================================================
module audio_dc_block_out #(
  parameter int ALPHA_SHIFT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [15:0] in,
  input  logic [3:0]  volume,
  output logic [15:0] out,
  output logic        out_valid,
  output logic        clip,
  output logic        overrun
`ifdef AUDIO_DC_BLOCK_CLIP_COUNT_EN
  ,
  output logic [7:0]  clip_count
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CENTER = 3'd1,
    FILTER = 3'd2,
    SCALE  = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  localparam logic signed [39:0] SAT_MAX = 40'sd32767;
  localparam logic signed [39:0] SAT_MIN = -40'sd32768;

  state_t             state;
  state_t             state_next;
  logic [15:0]        in_lat;
  logic [3:0]         vol_lat;
  logic signed [16:0] x_cur;
  logic signed [16:0] x_prev;
  logic signed [39:0] y_prev;
  logic signed [16:0] x_center;
  logic signed [39:0] diff_ext;
  logic signed [39:0] y_new;
  logic signed [39:0] scaled;
  logic [15:0]        sat_val;
  logic               sat_hit;

  // Next-state logic: only IDLE waits; every other state lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_valid) state_next = CENTER;
      CENTER:  state_next = FILTER;
      FILTER:  state_next = SCALE;
      SCALE:   state_next = OUTPUT;
      OUTPUT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: recentre, high-pass update, attenuate, then saturate.
  always_comb begin
    x_center = $signed({1'b0, in_lat}) - $signed(17'd32768);
    diff_ext = {{23{x_cur[16]}}, x_cur} - {{23{x_prev[16]}}, x_prev};
    y_new    = (diff_ext <<< 16) + y_prev - (y_prev >>> ALPHA_SHIFT);
    // y_prev already holds the filter output of this sample during SCALE.
    scaled   = (y_prev >>> 16) >>> vol_lat;
    sat_hit  = 1'b0;
    sat_val  = scaled[15:0];
    if (scaled > SAT_MAX) begin
      sat_val = 16'h7FFF;
      sat_hit = 1'b1;
    end else if (scaled < SAT_MIN) begin
      sat_val = 16'h8000;
      sat_hit = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Sample/volume capture, centred sample and filter history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_lat  <= 16'd0;
      vol_lat <= 4'd0;
      x_cur   <= 17'sd0;
      x_prev  <= 17'sd0;
      y_prev  <= 40'sd0;
    end else begin
      if (state == IDLE && sample_valid) begin
        in_lat  <= in;
        vol_lat <= volume;
      end
      if (state == CENTER) x_cur <= x_center;
      if (state == FILTER) begin
        x_prev <= x_cur;
        y_prev <= y_new;
      end
    end
  end

  // Output register: loaded at the end of SCALE so out_valid is seen in OUTPUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out       <= 16'd0;
      out_valid <= 1'b0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= (state == SCALE);
      clip      <= (state == SCALE) && sat_hit;
      overrun   <= sample_valid && (state != IDLE);
      if (state == SCALE) out <= sat_val;
    end
  end

`ifdef AUDIO_DC_BLOCK_CLIP_COUNT_EN
  // Saturating tally of clip pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         clip_count <= 8'd0;
    else if (clip && clip_count != 8'hFF) clip_count <= clip_count + 8'd1;
  end
`endif

endmodule
`default_nettype wire
